// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first with a valid qualifier.
// Optional even-parity bit after the LSB when SEQ_TX_PARITY_EN is defined.
module seq_pattern_tx #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int unsigned      GAP     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_cnt
);

`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = PAT_W + 1;
`else
  localparam int unsigned FRAME_LEN = PAT_W;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pattern, pattern_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [3:0]       gap_cnt, gap_nxt;
  logic [7:0]       cnt_nxt;
  logic             last_bit;
  logic             frame_end;
  logic             x_out_nxt, x_valid_nxt, busy_nxt;
  logic [PAT_W-1:0] shifted;

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= S_IDLE;
      pattern   <= PATTERN;
      idx       <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      x_out     <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pattern   <= pattern_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= gap_nxt;
      frame_cnt <= cnt_nxt;
      x_out     <= x_out_nxt;
      x_valid   <= x_valid_nxt;
      busy      <= busy_nxt;
      done      <= frame_end;
    end
  end

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    idx_nxt     = idx;
    gap_nxt     = gap_cnt;
    cnt_nxt     = frame_cnt;
    frame_end   = 1'b0;
    last_bit    = (state == S_SEND) && (idx == LAST_IDX);

    // The count still advances when abort lands on the final bit
    if (last_bit) cnt_nxt = frame_cnt + 8'd1;

    if (abort) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pat_load) pattern_nxt = pat_in;
          if (start) begin
            state_nxt = S_SEND;
            idx_nxt   = '0;
          end
        end
        S_SEND: begin
          if (last_bit) begin
            idx_nxt = '0;
            if (GAP != 0) begin
              state_nxt = S_GAP;
              gap_nxt   = '0;
            end else if (!cont) begin
              state_nxt = S_IDLE;
              frame_end = 1'b1;
            end
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_nxt = '0;
            if (cont) begin
              state_nxt = S_SEND;
              idx_nxt   = '0;
            end else begin
              state_nxt = S_IDLE;
              frame_end = 1'b1;
            end
          end else begin
            gap_nxt = gap_cnt + 4'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave the register with it;
  // pattern_nxt lets a same-cycle load+start send the freshly loaded pattern.
  always_comb begin
    shifted     = pattern_nxt << idx_nxt;
    x_valid_nxt = (state_nxt == S_SEND);
    busy_nxt    = (state_nxt != S_IDLE);
    x_out_nxt   = 1'b0;
    if (x_valid_nxt) begin
      x_out_nxt = shifted[PAT_W-1];
`ifdef SEQ_TX_PARITY_EN
      if (idx_nxt == 4'(PAT_W)) x_out_nxt = ^pattern_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx, run at GAP=2 and GAP=0 side by side.
`timescale 1ns/1ps
module tb_seq_pattern_tx;

  localparam int PW = 4;
`ifdef SEQ_TX_PARITY_EN
  localparam int L = PW + 1;
`else
  localparam int L = PW;
`endif
  localparam logic [3:0] DEF_PAT = 4'b1101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit fin [2];

  function automatic void check(int cfg, string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", cfg, name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int GAPV = (g == 0) ? 2 : 0;

    logic       rst_n = 1'b1, start = 1'b0, cont = 1'b0, abort = 1'b0, pat_load = 1'b0;
    logic [3:0] pat_in = '0;
    logic       x_out, x_valid, busy, done;
    logic [7:0] frame_cnt;

    bit         exp_bits[$];
    int         exp_done[$];
    logic [3:0] model_pat = DEF_PAT;
    int         model_cnt = 0;

    seq_pattern_tx #(.PAT_W(PW), .PATTERN(DEF_PAT), .GAP(GAPV)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
      .pat_load(pat_load), .pat_in(pat_in), .x_out(x_out), .x_valid(x_valid),
      .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    function automatic bit exp_bit(logic [3:0] p, int i);
      if (i < PW) return p[PW-1-i];
      return ^p;
    endfunction

    task automatic run_txn(int mode, logic [3:0] newp, int n, int ak);
      int seen = 0;
      bit aborted = 0;
      bit finished = 0;
      int budget = n * (L + GAPV) + 20;
      @(negedge clk);
      if (mode == 2) begin
        pat_load = 1; pat_in = newp; model_pat = newp;
        @(negedge clk);
        pat_load = 0;
      end else if (mode == 1) begin
        pat_load = 1; pat_in = newp; model_pat = newp;
      end
      for (int j = 0; j < ((ak != 0) ? ak : n * L); j++) exp_bits.push_back(exp_bit(model_pat, j % L));
      if (ak == 0) begin
        model_cnt += n;
        exp_done.push_back(model_cnt & 255);
      end else if (ak == L) begin
        model_cnt += 1;
      end
      start = 1;
      cont = (n > 1);
      for (int c = 0; c < budget && !finished; c++) begin
        @(negedge clk);
        start = 0; pat_load = 0; abort = 0;
        if (x_valid) seen++;
        if (!busy && seen > 0) finished = 1;
        else if (busy) begin
          if (seen >= (n - 1) * L + 1) cont = 0;
          if (ak != 0 && seen == ak && !aborted) begin
            abort = 1; aborted = 1;
          end else if ($urandom_range(3) == 0) begin
            start = 1; pat_load = 1; pat_in = 4'($urandom_range(15));
          end
        end
      end
      if (!finished) check(g, "txn_timeout_busy", busy, 0);
      @(negedge clk);
      cont = 0;
      check(g, "bits_outstanding", exp_bits.size(), 0);
      check(g, "done_outstanding", exp_done.size(), 0);
      check(g, "frame_cnt", frame_cnt, model_cnt & 255);
    endtask

    task automatic reset_mid_frame();
      int seen = 0;
      @(negedge clk);
      for (int j = 0; j < L; j++) exp_bits.push_back(exp_bit(model_pat, j));
      start = 1;
      for (int c = 0; c < 20 && seen < 2; c++) begin
        @(negedge clk);
        start = 0;
        if (x_valid) seen++;
      end
      check(g, "rst_setup_bits", seen, 2);
      @(posedge clk);
      #2 rst_n = 1;
      #1;
      check(g, "rst_x_valid", x_valid, 0);
      check(g, "rst_busy", busy, 0);
      check(g, "rst_x_out", x_out, 0);
      check(g, "rst_done", done, 0);
      check(g, "rst_frame_cnt", frame_cnt, 0);
      exp_bits.delete();
      exp_done.delete();
      model_pat = DEF_PAT;
      model_cnt = 0;
      @(negedge clk);
      #1 rst_n = 0;
    endtask

    initial begin : driver
      repeat (3) @(negedge clk);
      check(g, "init_busy", busy, 0);
      check(g, "init_frame_cnt", frame_cnt, 0);
      #1 rst_n = 0;
      run_txn(0, 4'h0, 1, 0);
      run_txn(1, 4'b1011, 1, 0);
      run_txn(0, 4'h0, 2, 0);
      run_txn(0, 4'h0, 3, 0);
      run_txn(0, 4'h0, 1, 2);
      run_txn(2, 4'b0110, 1, L);
      reset_mid_frame();
      run_txn(0, 4'h0, 1, 0);
      for (int t = 0; t < 20; t++) begin
        int ak = ($urandom_range(3) == 0) ? 1 + $urandom_range(L - 1) : 0;
        int n = (ak != 0) ? 1 : 1 + $urandom_range(2);
        run_txn($urandom_range(2), 4'($urandom_range(15)), n, ak);
      end
      run_txn(0, 4'h0, 260, 0);
      fin[g] = 1;
    end

    initial begin : monitor
      int run = 0;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          run = 0;
        end else begin
          if (x_valid) begin
            if (exp_bits.size() == 0) check(g, "x_valid_unexpected", x_valid, 0);
            else check(g, "x_out", x_out, exp_bits.pop_front());
          end else begin
            check(g, "x_out_when_invalid", x_out, 0);
          end
          if (busy && !x_valid) run++;
          else begin
            if (run > 0) check(g, "gap_len", run, GAPV);
            run = 0;
          end
          if (done) begin
            if (exp_done.size() == 0) check(g, "done_unexpected", done, 0);
            else check(g, "done_frame_cnt", frame_cnt, exp_done.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, got %0d vectors expected completion", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    wait (fin[0] && fin[1]);
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter, the sending end of the Moore sequence-detector path. Holds a PAT_W-bit pattern and shifts it out MSB-first on a single serial line, one bit per clock, with a valid qualifier. It supports single-shot or continuous framing with a programmable idle gap, so the detector's serial input (ui_in[0] on the tile) can be driven on-chip or in loopback benches. All outputs are registered (Moore style).

Parameters:
PAT_W, 4, pattern/frame width in bits (2..8).
PATTERN, 4'b1101, reset value of the pattern register (the detector's target sequence).
GAP, 2, idle cycles (x_valid=0, x_out=0) after each frame (0..15; 0 = back-to-back).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-high (rst_n=1 resets)
start  input  1  begin a frame; sampled only in IDLE
cont  input  1  continuous mode; sampled at frame end
abort  input  1  synchronous abort to IDLE
pat_load  input  1  load pat_in into pattern register; honoured only in IDLE
pat_in  input  PAT_W  new pattern
x_out  output  1  serial data bit
x_valid  output  1  x_out carries a pattern bit
busy  output  1  high in SEND and GAP
done  output  1  one-cycle pulse on return to IDLE after a completed frame
frame_cnt  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, pattern=PATTERN, bit counter=0, gap counter=0. x_out=0, x_valid=0, busy=0, done=0, frame_cnt=0.
- States: IDLE, SEND, GAP.
- IDLE: x_valid=0, x_out=0, busy=0.
  - pat_load=1: pattern<=pat_in.
  - start=1: ->SEND.
  - pat_load and start in the same cycle: the load takes effect and the frame sends the new pattern.
- SEND: start sampled at edge N, so x_out=pattern[PAT_W-1], x_valid=1, busy=1 after edge N.
  - Bit i (MSB-first) is presented after edge N+i and held exactly one cycle. The last bit is presented after edge N+PAT_W-1.
  - After the last bit, frame_cnt increments by 1 (8-bit wrap).
  - GAP>0: ->GAP.
  - GAP=0 with cont=1: next frame's MSB follows immediately, with no idle cycle.
  - GAP=0 with cont=0: ->IDLE with done=1.
- GAP: x_valid=0, x_out=0, busy=1 for exactly GAP cycles.
  - cont is sampled in the last gap cycle. cont=1: ->SEND. cont=0: ->IDLE with done=1.
- done: high exactly one cycle, in the first IDLE cycle. Never asserted after abort.
- start while busy: ignored, with no queueing. pat_load while busy: ignored; the pattern is unchanged.
- abort=1 (any state, priority over start/cont/pat_load): state=IDLE at next edge, x_valid=0, x_out=0, busy=0, done=0. frame_cnt is unchanged unless the aborted cycle was the last bit of the frame; in that case the increment still happens.
- Pattern register is stable during a frame. Shifting uses an internal copy or index, never destructive on the pattern register.

Optional Feature:
SEQ_TX_PARITY_EN
- Defined: one even-parity bit (XOR of all pattern bits) is appended after the LSB. Frame = PAT_W+1 valid cycles. frame_cnt and done timing shift by one cycle accordingly.
- Undefined: frame = PAT_W bits, with no parity logic present.

Test Plan:
1. Assert rst_n=1 mid-frame between clock edges -> x_valid, busy, x_out, done, frame_cnt all 0 immediately. Then release and pulse start -> 1,1,0,1 sent.
2. Default PATTERN=1101, GAP=2, one-cycle start -> x_out=1,1,0,1 with x_valid=1 for 4 cycles. Then 2 cycles x_valid=0, busy=1. Then done=1 for one cycle and frame_cnt=1.
3. pat_load with pat_in=4'b1011 in IDLE, then start -> 1,0,1,1. pat_load=4'b0000 during the frame -> ignored; the next frame still sends 1,0,1,1.
4. cont=1 held, start once -> frames repeat with exactly 2 idle cycles between. Drop cont during frame 3 -> stop after frame 3 gap, done pulse, frame_cnt=3. Repeat with GAP=0 -> 8 consecutive valid bits for 2 frames.
5. abort after 2 bits -> x_valid=0 next cycle, done stays 0, frame_cnt unchanged. start pulsed while busy -> no effect on sequence or count.
6. Loopback into the Moore detector, x_out -> x1, continuous 1101 -> detector y reaches state 011 after each frame's final 1. With SEQ_TX_PARITY_EN defined -> frame is 1,1,0,1,1 (parity of 1101 = 1).
